regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//  Parametrised register file for the CPU datapath, replacing the fixed 2R/1W, 32x64 file.
//  Generalised in register width and depth, and in the number of read and write ports.
//  Adds optional hardwired zero register, write-to-read bypass, prioritised multi-write,
//  and a post-reset clear sweep gated by a ready flag. Sits between decode and execute.
//  Read addresses are taken from instruction fields [19:15]/[24:20]; write address from [11:7].
// PARAMETERS
//  XLEN      64   data width of each register
//  NUM_REGS  32   number of architectural registers (>=2)
//  AW        $clog2(NUM_REGS)  address width (derived, not overridden)
//  NRP       2    number of read ports (>=1)
//  NWP       1    number of write ports (>=1)
//  ZERO_REG  1    1: register 0 reads 0 and ignores writes
//  BYPASS    1    1: a same-cycle write is forwarded to matching reads
// PORTS
//  clock    in   1         rising-edge clock; the only clock
//  reset    in   1         synchronous, active-high
//  rd_addr  in   NRP*AW    read address, port p at [p*AW +: AW]
//  rd_data  out  NRP*XLEN  read data, port p at [p*XLEN +: XLEN]
//  wr_en    in   NWP       per-port write enable
//  wr_addr  in   NWP*AW    write address, port w at [w*AW +: AW]
//  wr_data  in   NWP*XLEN  write data, port w at [w*XLEN +: XLEN]
//  ready    out  1         1 once the clear sweep completes; writes are accepted only when 1
// BEHAVIOUR
//  Storage: NUM_REGS x XLEN flops, every entry fully XLEN wide, so there is no truncation.
//  Address ranges:
//   - An address >= NUM_REGS reads 0.
//   - A write to an address >= NUM_REGS is dropped.
//  FSM states CLEAR and RUN, held in registers:
//   - reset=1: next state CLEAR, clr_idx<=0, ready<=0. Applies in any state (a mid-operation reset restarts the sweep).
//   - CLEAR: each cycle writes 0 to reg[clr_idx], then clr_idx++.
//   - At clr_idx==NUM_REGS-1 (after writing it): state<=RUN, ready<=1.
//   - The sweep takes exactly NUM_REGS cycles after reset deasserts.
//   - RUN: stays in RUN until the next reset.
//  Reset values: ready=0, state=CLEAR, clr_idx=0.
//   - Register contents are not reset directly; the sweep zeroes them.
//  Reads while ready=0: every rd_data port is forced to 0.
//  Writes while ready=0: wr_en is ignored.
//  Reads in RUN: combinational, zero latency. rd_data = reg[rd_addr] from the previous edge, with these overrides:
//   - ZERO_REG=1 and rd_addr==0: returns 0, regardless of bypass.
//   - BYPASS=1 and some wr_en[w] with wr_addr[w]==rd_addr this cycle: returns that wr_data.
//   - If several write ports match, the highest-index port wins.
//   - BYPASS=0: the new value is visible the cycle after the write edge.
//  Writes in RUN: registered on the rising edge, one cycle of write latency.
//   - Several ports enabled to the same address: the highest-index port wins, others are dropped.
//   - ZERO_REG=1: writes to address 0 are dropped and reg[0] stays 0.
//   - ZERO_REG=0: register 0 is an ordinary register.
//  Simultaneous reset and wr_en: reset wins, the write is dropped, and the sweep starts.
//  All read ports are independent; several ports may read the same address in one cycle.
// TESTING
//  T1: reset 1 cycle, NUM_REGS=32 -> ready=0 for exactly 32 cycles, ready=1 on cycle 33; all reads return 0.
//  T2: RUN, write reg5=64'hDEAD_BEEF_0123_4567 with BYPASS=1 -> rd_addr0=5 returns the value in the same cycle;
//      with BYPASS=0 the value appears the next cycle.
//  T3: ZERO_REG=1, write reg0=64'hFFFF... -> reading reg0 returns 0 in the same cycle and in later cycles.
//  T4: NWP=2, both ports write reg7 (port0=64'h1, port1=64'h2) -> reg7=64'h2, and the bypass read shows 64'h2.
//  T5: write reg9=64'hAA, then assert reset mid-run for 1 cycle -> ready drops, and after 32 cycles reg9 reads 0.
//  T6: wr_en=1 while ready=0 (mid-sweep) with reg3=64'h55 -> dropped; reg3 reads 0 after ready rises.

Source files
------------

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file for the decode/execute boundary.
// After reset a clear sweep zeroes every entry; reads and writes are live once ready is high.
`timescale 1ns/1ps

module regfile_multiport #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int NRP      = 2,
  parameter int NWP      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*XLEN-1:0] wr_data,
  output logic                ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            ready_q, ready_d;
  logic            clear_we;
  logic [NWP-1:0]  wr_act;

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    clear_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clear_we = 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign ready = ready_q;

  // ---------------------------------------------------------------------------
  // Write qualification: shared by the storage update and the read bypass, so a
  // dropped write (not ready, reset, out of range, zero register) is never forwarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_act = '0;
    for (int unsigned w = 0; w < NWP; w++) begin
      wr_act[w] = wr_en[w] & ready_q & ~reset
                & in_range(wr_addr[w*AW +: AW])
                & ~is_zero_reg(wr_addr[w*AW +: AW]);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (clear_we) begin
      regs_d[clr_idx_q] = '0;
    end
    // Ascending port order: the highest-index port lands last and wins.
    for (int unsigned w = 0; w < NWP; w++) begin
      if (wr_act[w]) begin
        regs_d[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock) begin
    regs_q <= regs_d;
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NRP; p++) begin
      if (ready_q && in_range(rd_addr[p*AW +: AW]) && !is_zero_reg(rd_addr[p*AW +: AW])) begin
        rd_data[p*XLEN +: XLEN] = regs_q[rd_addr[p*AW +: AW]];
        if (BYPASS != 0) begin
          for (int unsigned w = 0; w < NWP; w++) begin
            if (wr_act[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
              rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

endmodule
